// File: rtl/fir_input_deser_l3.sv
// Serial-to-parallel front end for an L=3 polyphase FIR: gathers three samples per block.
// Optional macro FIR_DESER_FLUSH_EN adds a flush input that emits a zero-padded partial block.
module fir_input_deser_l3 #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data1,
  output logic signed [DATA_W-1:0] out_data2,
  output logic signed [DATA_W-1:0] out_data3,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef FIR_DESER_FLUSH_EN
  input  logic                     flush,
  output logic                     out_partial,
`endif
  output logic [CNT_W-1:0]         block_count
);

  typedef enum logic [1:0] {FILL0, FILL1, FILL2} fill_t;

  fill_t                     fill, fill_nxt;
  logic signed [DATA_W-1:0]  lane1, lane2, lane1_nxt, lane2_nxt;
  logic signed [DATA_W-1:0]  ld1, ld2, ld3;
  logic                      load, ld_partial, accept, consume;
`ifdef FIR_DESER_FLUSH_EN
  logic                      out_free;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    fill_nxt   = fill;
    lane1_nxt  = lane1;
    lane2_nxt  = lane2;
    load       = 1'b0;
    ld_partial = 1'b0;
    ld1        = lane1;
    ld2        = lane2;
    ld3        = in_data;

    // Only the block-completing sample can be stalled by a full output register.
    in_ready = !((fill == FILL2) && out_valid && !out_ready);
    accept   = in_valid && in_ready;
    consume  = out_valid && out_ready;

    unique case (fill)
      FILL0: if (accept) begin
        lane1_nxt = in_data;
        fill_nxt  = FILL1;
      end
      FILL1: if (accept) begin
        lane2_nxt = in_data;
        fill_nxt  = FILL2;
      end
      FILL2: if (accept) begin
        load      = 1'b1;
        lane1_nxt = '0;
        lane2_nxt = '0;
        fill_nxt  = FILL0;
      end
      default: fill_nxt = FILL0;
    endcase

`ifdef FIR_DESER_FLUSH_EN
    out_free = !out_valid || out_ready;
    // A flush that coincides with the completing sample is just a normal full block.
    if (flush && (fill != FILL0) && out_free && !load) begin
      load       = 1'b1;
      ld_partial = 1'b1;
      ld1        = lane1;
      ld2        = (fill == FILL2) ? lane2 : (accept ? in_data : '0);
      ld3        = '0;
      lane1_nxt  = '0;
      lane2_nxt  = '0;
      fill_nxt   = FILL0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the data registers are reset too, because zero lanes after reset are an observable contract.
      fill        <= FILL0;
      lane1       <= '0;
      lane2       <= '0;
      out_data1   <= '0;
      out_data2   <= '0;
      out_data3   <= '0;
      out_valid   <= 1'b0;
      block_count <= '0;
`ifdef FIR_DESER_FLUSH_EN
      out_partial <= 1'b0;
`endif
    end else begin
      fill  <= fill_nxt;
      lane1 <= lane1_nxt;
      lane2 <= lane2_nxt;
      if (load) begin
        out_data1 <= ld1;
        out_data2 <= ld2;
        out_data3 <= ld3;
        out_valid <= 1'b1;
`ifdef FIR_DESER_FLUSH_EN
        out_partial <= ld_partial;
`endif
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      if (consume) block_count <= block_count + CNT_W'(1);
    end
  end

`ifndef FIR_DESER_FLUSH_EN
  logic unused_partial;
  assign unused_partial = ld_partial;
`endif

endmodule
